// File: rtl/qdi_pkg.sv
// Shared e1of2 rail encodings and receiver state type for the dual-rail channel.
package qdi_pkg;

  localparam logic [1:0] E1OF2_NEUTRAL = 2'b00;
  localparam logic [1:0] E1OF2_D0      = 2'b01;
  localparam logic [1:0] E1OF2_D1      = 2'b10;
  localparam logic [1:0] E1OF2_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    WAIT_DATA,
    WAIT_NEUTRAL,
    STALL
  } rx_state_t;

endpackage

// File: rtl/qdi1of2_to_bin_rx_fifo.sv
// Single-bit circular FIFO; pointers wrap naturally since DEPTH is a power of two.
module bit_fifo
  import qdi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign w_pop = pop && !empty;
  assign dout  = r_mem[r_rd];
  assign count = r_count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_mem   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      r_count <= r_count + CW'(push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/qdi1of2_to_bin_rx.sv
// Receives e1of2 dual-rail tokens from a QDI circuit and presents them as a
// clocked valid/ready bit stream; Le provides backpressure into the circuit.
module qdi1of2_to_bin_rx
  import qdi_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [1:0]             L,
  output logic                   Le,
  output logic                   dout,
  output logic                   dvalid,
  input  logic                   dready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [1:0]    r_sync [SYNC_STAGES];
  rx_state_t     r_state;
  rx_state_t     w_state_next;
  logic          r_le;
  logic          r_push;
  logic          r_din;
  logic [1:0]    r_cap;
  logic          r_err;

  logic [1:0]    w_ls;
  logic          w_valid;
  logic          w_push;
  logic          w_err_set;
  logic          w_le_next;
  logic          w_pop;
  logic          w_space;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_next;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= E1OF2_NEUTRAL;
    end else begin
      r_sync[0] <= L;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_ls    = r_sync[SYNC_STAGES-1];
  assign w_valid = (w_ls == E1OF2_D0) || (w_ls == E1OF2_D1);

  // Push is registered one stage ahead of the FIFO, so the space check must
  // count a push still in flight as well as a pop landing this cycle.
  assign w_pop        = dready && !w_empty;
  assign w_count_next = w_count + CW'(r_push) - CW'(w_pop);
  assign w_space      = (w_count_next < CW'(DEPTH));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= WAIT_DATA;
      r_le    <= 1'b1;
      r_push  <= 1'b0;
      r_din   <= 1'b0;
      r_cap   <= E1OF2_NEUTRAL;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_le    <= w_le_next;
      r_push  <= w_push;
      if (w_push) begin
        r_din <= w_ls[1];
        r_cap <= w_ls;
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WAIT_DATA:    if (w_valid) w_state_next = WAIT_NEUTRAL;
      WAIT_NEUTRAL: if (w_ls == E1OF2_NEUTRAL) w_state_next = w_space ? WAIT_DATA : STALL;
      STALL:        if (w_space) w_state_next = WAIT_DATA;
      default:      w_state_next = WAIT_DATA;
    endcase
  end

  always_comb begin
    w_push    = (r_state == WAIT_DATA) && w_valid;
    w_err_set = (w_ls == E1OF2_ILLEGAL) ||
                ((r_state == WAIT_NEUTRAL) && w_valid && (w_ls != r_cap));
    w_le_next = (w_state_next == WAIT_DATA);
  end

  bit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (r_push),
    .din   (r_din),
    .pop   (w_pop),
    .dout  (dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  a_no_overflow: assert property (@(posedge CLK) disable iff (RESET)
    !(r_push && w_full && !w_pop));

  assign Le     = r_le;
  assign dvalid = !w_empty;
  assign count  = w_count;
  assign err    = r_err;

endmodule
